// File: rtl/serial_add_ctrl_if.sv
// Start/done handshake plus operand and result bus for serial_add_ctrl.
// Defining SERIAL_ADD_SUB_EN adds the sub request bit.
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (output start, a, b, cin, sub, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB-first across a WIDTH-bit add.
// Defining SERIAL_ADD_SUB_EN adds a subtract mode (a - b) selected by bus.sub at start.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, next_state;
    logic [WIDTH-1:0] a_sr, b_sr, sum_q;
    logic             carry_q, cout_q;
    logic [CW-1:0]    cnt_q;
    logic             fa_sum, fa_cout;
    logic             busy, done;
    logic             sub_req;

`ifdef SERIAL_ADD_SUB_EN
    assign sub_req = bus.sub;
`else
    assign sub_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= next_state;
    end

    always_comb begin
        next_state = state_q;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_q)
            IDLE: if (bus.start) next_state = RUN;
            RUN: begin
                busy = 1'b1;
                if (cnt_q == LAST) next_state = DONE;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // The shared full-adder cell, fed from the operand LSBs and the running carry.
    always_comb begin
        fa_sum  = a_sr[0] ^ b_sr[0] ^ carry_q;
        fa_cout = (a_sr[0] & b_sr[0]) | (carry_q & (a_sr[0] ^ b_sr[0]));
    end

    // Subtraction reuses the adder as a + ~b + 1, so cout=1 means no borrow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_sr    <= bus.a;
                        b_sr    <= sub_req ? ~bus.b : bus.b;
                        carry_q <= sub_req ? 1'b1 : bus.cin;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    sum_q   <= {fa_sum, sum_q[WIDTH-1:1]};
                    carry_q <= fa_cout;
                    if (cnt_q == LAST) cout_q <= fa_cout;
                    else               cnt_q  <= cnt_q + CW'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: expectations queued at drive time, checked on each done pulse.
// Defining SERIAL_ADD_SUB_EN also exercises the subtract mode.
module tb_serial_add_ctrl;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        int               doneCycle;
        string            tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cycle = 0;
    int   checkCount = 0;
    int   passCount = 0;
    int   doneCount = 0;
    exp_t sb[$];
    exp_t monExp;

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, actual, expected, cycle);
    endtask

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                            input logic cin, input logic sub);
        if (sub) return {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        return {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
    endfunction

    task automatic pushExp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub, input int doneCycle);
        exp_t e;
        logic [WIDTH:0] r;
        r           = model(a, b, cin, sub);
        e.sum       = r[WIDTH-1:0];
        e.cout      = r[WIDTH];
        e.doneCycle = doneCycle;
        e.tag       = tag;
        sb.push_back(e);
    endtask

    task automatic driveOps(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic cin, input logic sub);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = sub;
`endif
    endtask

    // One-cycle start; operands are scrambled right after acceptance and must not matter.
    task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
        @(negedge clk);
        driveOps(a, b, cin, sub);
        bus.start = 1'b1;
        pushExp(tag, a, b, cin, sub, cycle + 1 + WIDTH);
        @(negedge clk);
        bus.start = 1'b0;
        driveOps(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), sub);
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 4 * WIDTH + 10 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checkOutput("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            doneCount++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                monExp = sb.pop_front();
                checkOutput({monExp.tag, "_sum"}, 64'(bus.sum), 64'(monExp.sum));
                checkOutput({monExp.tag, "_cout"}, 64'(bus.cout), 64'(monExp.cout));
                checkOutput({monExp.tag, "_latency"}, 64'(cycle), 64'(monExp.doneCycle));
            end
        end
    end

    initial begin
        int c0;
        int doneBefore;
        bus.start = 1'b0;
        driveOps('0, '0, 1'b0, 1'b0);

        #12;
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_sum",  64'(bus.sum),  64'd0);
        checkOutput("reset_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] basic add with busy window");
        applyStimulus("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < WIDTH; i++) begin
            checkOutput("busy_run", 64'(bus.busy), 64'd1);
            @(negedge clk);
        end
        checkOutput("busy_at_done", 64'(bus.busy), 64'd0);
        checkOutput("done_pulse", 64'(bus.done), 64'd1);
        waitIdle();

        $display("[TB] carry boundaries");
        applyStimulus("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0);
        waitIdle();
        applyStimulus("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0);
        waitIdle();
        applyStimulus("add_00_00_c", 8'h00, 8'h00, 1'b1, 1'b0);
        waitIdle();

        $display("[TB] start during RUN is ignored");
        doneBefore = doneCount;
        applyStimulus("add_12_34", 8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        driveOps(8'hFF, 8'hFF, 1'b1, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitIdle();
        repeat (WIDTH + 4) @(negedge clk);
        checkOutput("single_done", 64'(doneCount - doneBefore), 64'd1);

        $display("[TB] async reset mid-RUN");
        @(negedge clk);
        driveOps(8'hAB, 8'h11, 1'b0, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("busy_before_reset", 64'(bus.busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkOutput("abort_sum",  64'(bus.sum),  64'd0);
        checkOutput("abort_cout", 64'(bus.cout), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus("add_01_01", 8'h01, 8'h01, 1'b0, 1'b0);
        waitIdle();

        $display("[TB] start held high, back-to-back");
        @(negedge clk);
        c0 = cycle;
        driveOps(8'h80, 8'h80, 1'b0, 1'b0);
        bus.start = 1'b1;
        pushExp("b2b_1", 8'h80, 8'h80, 1'b0, 1'b0, c0 + 1 + WIDTH);
        @(negedge clk);
        driveOps(8'h7F, 8'h01, 1'b1, 1'b0);
        pushExp("b2b_2", 8'h7F, 8'h01, 1'b1, 1'b0, c0 + 1 + WIDTH + (WIDTH + 2));
        repeat (WIDTH + 2) @(negedge clk);
        driveOps(8'hC3, 8'h3C, 1'b0, 1'b0);
        pushExp("b2b_3", 8'hC3, 8'h3C, 1'b0, 1'b0, c0 + 1 + WIDTH + 2 * (WIDTH + 2));
        repeat (WIDTH + 2) @(negedge clk);
        bus.start = 1'b0;
        waitIdle();

`ifdef SERIAL_ADD_SUB_EN
        $display("[TB] subtract mode");
        applyStimulus("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1);
        waitIdle();
        applyStimulus("sub_00_01", 8'h00, 8'h01, 1'b1, 1'b1);
        waitIdle();
        applyStimulus("add_after_sub", 8'h21, 8'h10, 1'b1, 1'b0);
        waitIdle();
`endif

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: time-multiplexes a single instance of the team's 1-bit full_adder cell across a WIDTH-bit add.
- Operands are processed LSB-first, one bit per clock.
- Trades latency for area versus a ripple array; drives the adder from a start/done handshake for use under a slow sequencer or CPU-side register block.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepted start
- b  input  WIDTH  operand B; captured on the accepted start
- cin  input  1  carry-in; captured on the accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  result; held until the next accepted start
- cout  output  1  final carry; held with sum

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Operand shift registers, carry register and bit counter all go to 0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start=1 at a clock edge:
  - Capture a and b into shift registers; carry register <= cin; counter <= 0.
  - Go to RUN.
- IDLE, start=0: remain in IDLE; outputs hold.
- RUN, each cycle:
  - full_adder inputs: a_sr[0], b_sr[0], carry register.
  - a_sr and b_sr shift right by one.
  - The sum bit shifts into sum at the MSB; sum shifts right, so after WIDTH shifts bit 0 sits at sum[0].
  - Carry register <= full_adder carry-out; counter increments.
  - When the counter reaches WIDTH-1, that cycle's edge completes the last bit, then go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - cout equals the carry register.
  - Go to IDLE.
- Latency: start sampled at edge k gives busy=1 for edges k+1..k+WIDTH, and done=1 in the cycle after edge k+WIDTH. Total is WIDTH+1 cycles from accept to the done pulse.
- Intermediate values:
  - sum is a partially shifted value during RUN and is valid only from done onward.
  - cout is updated on entry to DONE only.
- start while in RUN or DONE is ignored; no queuing, no abort. start held high continuously re-triggers on the first IDLE cycle after done, giving back-to-back operations every WIDTH+2 cycles.
- Operand changes on a/b/cin after acceptance have no effect.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
- Counter width is $clog2(WIDTH); it does not wrap mid-operation.
- Reset asserted mid-RUN aborts immediately; outputs take reset values, and the next start after release behaves normally.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN
- With the macro defined:
  - Extra input port sub (1 bit), captured on start.
  - sub=1 computes a - b: b is inverted on capture and the carry register is loaded with 1, ignoring cin. cout=1 means no borrow (a >= b unsigned).
  - sub=0 gives the add behaviour above.
- Without the macro: no sub port; add only.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, cin=0, one-cycle start -> busy high 8 cycles; done pulse 9 cycles after accept; sum=0x96, cout=0.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1; a=0, b=0, cin=1 -> sum=0x01, cout=0.
- Start 0x12+0x34, then pulse start with a=0xFF, b=0xFF during cycle 3 of RUN -> ignored; result 0x46, cout=0; a single done pulse.
- rst_n low at RUN cycle 4 -> busy, done, sum and cout all 0 asynchronously. Then 0x01+0x01 after release -> 0x02, with normal latency.
- start held high for 3 operations -> three done pulses spaced 10 cycles apart; each result is correct for the operands present at its accept edge.
- SERIAL_ADD_SUB_EN: sub=1, 0x10-0x01 -> 0x0F, cout=1; 0x00-0x01 -> 0xFF, cout=0. Without the macro, the bench compiles with no sub port.
